// File: rtl/video_fetch.sv
`timescale 1ns/1ps
// video_fetch
//
// Character-slot video fetcher and pixel serializer, sitting directly behind
// the CRTC. Each character slot (opened by cclk_en) captures the CRTC's
// display enable, memory address and raster line. It then reads the
// character code from video RAM and the glyph row from character ROM over
// the shared bus. The eight pixels are shifted out during the following
// slot, two clk16 cycles per pixel.
//
// Ports
//   clk16     in   16 MHz system clock, the only clock
//   reset     in   synchronous active-high reset
//   cclk_en   in   one-cycle strobe opening a character slot
//   de        in   display enable for the slot (sampled on cclk_en)
//   ma[9:0]   in   character address (sampled on cclk_en)
//   ra[2:0]   in   raster line within the character row (sampled on cclk_en)
//   graphic   in   charset select, ROM address bit 10 (sampled on cclk_en)
//   bus_req   out  read request, held until acknowledged
//   bus_addr  out  read address, valid while bus_req=1 (0 otherwise)
//   bus_ack   in   one-cycle acknowledge, bus_data valid in the same cycle
//   bus_data  in   read data
//   video     out  serialized pixel, 1 = lit, leftmost pixel first
//   underrun  out  one-cycle pulse when a fetch misses its slot deadline
module video_fetch #(
    parameter logic [16:0] VRAM_BASE = 17'h08000,
    parameter logic [16:0] CROM_BASE = 17'h10000
) (
    input  logic        clk16,
    input  logic        reset,
    input  logic        cclk_en,
    input  logic        de,
    input  logic [9:0]  ma,
    input  logic [2:0]  ra,
    input  logic        graphic,
    output logic        bus_req,
    output logic [16:0] bus_addr,
    input  logic        bus_ack,
    input  logic [7:0]  bus_data,
    output logic        video,
    output logic        underrun
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_CHAR,
        FETCH_PIX,
        READY
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  ma_q;
    logic [2:0]  ra_q;
    logic        graphic_q;
    logic [7:0]  code;
    logic [7:0]  pattern;
    logic [7:0]  sr;
    logic [3:0]  slot_cnt;
    logic        fetching;

    assign fetching = (state == FETCH_CHAR) || (state == FETCH_PIX);
    assign video    = sr[7];

    // Next state and bus outputs. A slot strobe overrides everything,
    // including an ack arriving in the same cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        bus_req   = 1'b0;
        bus_addr  = '0;
        case (state)
            FETCH_CHAR: begin
                bus_req  = 1'b1;
                bus_addr = VRAM_BASE + {7'b0, ma_q};
                if (bus_ack) state_nxt = FETCH_PIX;
            end
            FETCH_PIX: begin
                bus_req  = 1'b1;
                bus_addr = CROM_BASE + {6'b0, graphic_q, code[6:0], ra_q};
                if (bus_ack) state_nxt = READY;
            end
            default: ;
        endcase
        if (cclk_en) state_nxt = de ? FETCH_CHAR : IDLE;
    end

    always_ff @(posedge clk16) begin
        // NOTE: all state here is written with <= so every register samples
        // the pre-edge values, e.g. sr loads from the old state and pattern.
        if (reset) begin
            state     <= IDLE;
            ma_q      <= '0;
            ra_q      <= '0;
            graphic_q <= 1'b0;
            code      <= '0;
            pattern   <= '0;
            sr        <= '0;
            slot_cnt  <= 4'd15;
            underrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            underrun <= cclk_en && fetching;

            if (cclk_en) begin
                ma_q      <= ma;
                ra_q      <= ra;
                graphic_q <= graphic;
                slot_cnt  <= '0;
                // Only a completed fetch is displayed; bit 7 of the code
                // selects inverse video.
                sr        <= (state == READY) ? (pattern ^ {8{code[7]}}) : 8'h00;
            end else begin
                if (slot_cnt != 4'd15) slot_cnt <= slot_cnt + 4'd1;
                // Shift on odd counts 1..13 so each pixel lasts two cycles and
                // pixel 7 is held once the counter saturates.
                if (slot_cnt[0] && slot_cnt != 4'd15) sr <= {sr[6:0], 1'b0};
                if (bus_ack && state == FETCH_CHAR) code    <= bus_data;
                if (bus_ack && state == FETCH_PIX)  pattern <= bus_data;
            end
        end
    end

endmodule

// File: tb/tb_video_fetch.sv
`timescale 1ns/1ps
// Self-checking bench for video_fetch: directed slots pinned to hand-computed
// values, then randomized slots compared every cycle against a slot-level
// behavioural model.
module tb_video_fetch;

    localparam logic [16:0] VRAM_BASE = 17'h08000;
    localparam logic [16:0] CROM_BASE = 17'h10000;

    logic        clk16   = 1'b0;
    logic        reset   = 1'b1;
    logic        cclk_en = 1'b0;
    logic        de      = 1'b0;
    logic [9:0]  ma      = '0;
    logic [2:0]  ra      = '0;
    logic        graphic = 1'b0;
    logic        bus_ack = 1'b0;
    logic [7:0]  bus_data = '0;
    logic        bus_req;
    logic [16:0] bus_addr;
    logic        video;
    logic        underrun;

    video_fetch #(
        .VRAM_BASE(VRAM_BASE),
        .CROM_BASE(CROM_BASE)
    ) dut (
        .clk16   (clk16),
        .reset   (reset),
        .cclk_en (cclk_en),
        .de      (de),
        .ma      (ma),
        .ra      (ra),
        .graphic (graphic),
        .bus_req (bus_req),
        .bus_addr(bus_addr),
        .bus_ack (bus_ack),
        .bus_data(bus_data),
        .video   (video),
        .underrun(underrun)
    );

    always #31.25 clk16 = ~clk16;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Slot-level model: what the current slot is fetching, how many of its
    // two reads have been acknowledged, the byte on display and how long
    // ago the slot started.
    // ------------------------------------------------------------------
    bit         m_valid    = 0;
    bit         m_fetching = 0;
    bit         m_under    = 0;
    int         m_acks     = 0;
    int         m_age      = 1000;
    logic [9:0] m_ma       = '0;
    logic [2:0] m_ra       = '0;
    logic       m_gr       = 1'b0;
    logic [7:0] m_code     = '0;
    logic [7:0] m_pattern  = '0;
    logic [7:0] m_disp     = '0;

    always @(posedge clk16) begin
        if (reset) begin
            m_valid    <= 1;
            m_fetching <= 0;
            m_acks     <= 0;
            m_under    <= 0;
            m_disp     <= '0;
            m_age      <= 1000;
            m_code     <= '0;
            m_pattern  <= '0;
        end else if (cclk_en) begin
            m_disp     <= (m_fetching && m_acks == 2) ? (m_pattern ^ {8{m_code[7]}}) : 8'h00;
            m_under    <= m_fetching && m_acks < 2;
            m_fetching <= de;
            m_acks     <= 0;
            m_ma       <= ma;
            m_ra       <= ra;
            m_gr       <= graphic;
            m_age      <= 0;
        end else begin
            m_under <= 0;
            if (m_age < 1000) m_age <= m_age + 1;
            if (m_fetching && m_acks < 2 && bus_ack) begin
                if (m_acks == 0) m_code <= bus_data;
                else             m_pattern <= bus_data;
                m_acks <= m_acks + 1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk16) begin : compare
        logic        exp_req;
        logic [16:0] exp_addr;
        int          pix;
        if (m_valid) begin
            exp_req  = m_fetching && m_acks < 2;
            exp_addr = (m_acks == 0) ? VRAM_BASE + {7'b0, m_ma}
                                     : CROM_BASE + {6'b0, m_gr, m_code[6:0], m_ra};
            pix      = (m_age >= 14) ? 7 : m_age / 2;
            check("bus_req", bus_req, exp_req);
            if (exp_req) check("bus_addr", bus_addr, exp_addr);
            check("video", video, m_disp[7 - pix]);
            check("underrun", underrun, m_under);
        end
    end

    // ------------------------------------------------------------------
    // Slot driver: opens a slot, answers bus requests after the given
    // number of waiting cycles, and logs what it saw.
    // ------------------------------------------------------------------
    logic [16:0] addr_q[$];
    logic [15:0] vword;
    int          under_cnt = 0;
    bit          seen_req  = 0;

    task automatic slot(input bit s_de, input logic [9:0] s_ma, input logic [2:0] s_ra,
                        input bit s_gr, input logic [7:0] s_code, input logic [7:0] s_pat,
                        input int d_char, input int d_pix, input int len,
                        input bit late_ack, input int rst_at);
        int p   = 0;
        int cnt = 0;
        int dly[2];
        dly[0] = d_char;
        dly[1] = d_pix;
        addr_q.delete();
        vword   = '0;
        cclk_en = 1'b1;
        de      = s_de;
        ma      = s_ma;
        ra      = s_ra;
        graphic = s_gr;
        if (late_ack) begin
            bus_ack  = 1'b1;
            bus_data = 8'hEE;
        end
        for (int i = 0; i < len; i++) begin
            @(posedge clk16);
            #1;
            if (i < 16) vword[15 - i] = video;
            if (underrun) under_cnt++;
            if (bus_req) seen_req = 1;
            cclk_en = 1'b0;
            bus_ack = 1'b0;
            reset   = 1'b0;
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("reset_mid_req", bus_req, 0);
                check("reset_mid_video", video, 0);
                check("reset_mid_underrun", underrun, 0);
            end
            // The last sample is taken in the next slot's strobe cycle.
            if (i < len - 1) begin
                if (i == rst_at) begin
                    reset = 1'b1;
                end else if (bus_req && p < 2) begin
                    if (cnt >= dly[p]) begin
                        bus_ack  = 1'b1;
                        bus_data = (p == 0) ? s_code : s_pat;
                        addr_q.push_back(bus_addr);
                        p++;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    endtask

    int u0;

    initial begin
        repeat (3) @(posedge clk16);
        #1;
        reset = 1'b0;
        check("reset_bus_req", bus_req, 0);
        check("reset_bus_addr", bus_addr, 0);
        check("reset_video", video, 0);
        check("reset_underrun", underrun, 0);

        // Three blank slots: no fetches, dark screen.
        seen_req  = 0;
        under_cnt = 0;
        repeat (3) begin
            slot(0, 10'h011, 3'd1, 0, 8'h00, 8'h00, 0, 0, 16, 0, -1);
            check("blank_video", vword, 16'h0000);
        end
        check("blank_no_req", seen_req, 0);
        check("blank_no_underrun", under_cnt, 0);

        // Code 41, pattern A5.
        slot(1, 10'h005, 3'd3, 0, 8'h41, 8'hA5, 1, 1, 16, 0, -1);
        check("a_num_reads", addr_q.size(), 2);
        check("a_vram_addr", addr_q[0], 17'h08005);
        check("a_crom_addr", addr_q[1], 17'h1020B);

        // Code C1 (inverse) with the same glyph; shows A5 from the last slot.
        slot(1, 10'h005, 3'd3, 0, 8'hC1, 8'hA5, 1, 1, 16, 0, -1);
        check("a_video", vword, 16'hCC33);
        check("b_crom_addr", addr_q[1], 17'h1020B);

        // Graphic charset, code 00, raster 7; shows inverted A5 = 5A.
        slot(1, 10'h000, 3'd7, 1, 8'h00, 8'h81, 1, 1, 16, 0, -1);
        check("b_video", vword, 16'h33CC);
        check("c_crom_addr", addr_q[1], 17'h10407);

        // ROM ack never arrives in this slot; shows 81.
        u0 = under_cnt;
        slot(1, 10'h009, 3'd0, 0, 8'h12, 8'h34, 1, 40, 16, 0, -1);
        check("c_video", vword, 16'hC003);
        check("d_no_underrun_yet", under_cnt, u0);

        // Late ack lands on the strobe cycle and must be dropped.
        slot(1, 10'h3FF, 3'd1, 0, 8'h3C, 8'h0F, 1, 1, 16, 1, -1);
        check("d_blank_after_underrun", vword, 16'h0000);
        check("d_underrun_once", under_cnt, u0 + 1);
        check("e_num_reads", addr_q.size(), 2);
        check("e_vram_addr", addr_q[0], 17'h083FF);

        // Reset while the ROM read is outstanding.
        slot(1, 10'h002, 3'd0, 0, 8'h55, 8'h66, 0, 40, 16, 0, 6);
        check("f_no_underrun", under_cnt, u0 + 1);

        // Normal fetch after reset.
        slot(1, 10'h001, 3'd2, 0, 8'h7E, 8'hC3, 1, 1, 16, 0, -1);
        check("f_video_after_reset", vword, 16'h0000);
        check("g_vram_addr", addr_q[0], 17'h08001);
        check("g_crom_addr", addr_q[1], 17'h103F2);
        slot(0, 10'h000, 3'd0, 0, 8'h00, 8'h00, 0, 0, 16, 0, -1);
        check("g_video", vword, 16'hF00F);

        // Randomized slots: short and long slots, slow acks, late acks, resets.
        repeat (150) begin
            int len;
            int rst_at;
            int dc;
            int dp;
            len    = int'($urandom_range(6, 20));
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, len - 3)) : -1;
            dc     = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 5));
            dp     = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 5));
            slot($urandom_range(0, 3) != 0, 10'($urandom), 3'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), dc, dp, len, $urandom_range(0, 3) == 0, rst_at);
        end
        slot(0, 10'h000, 3'd0, 0, 8'h00, 8'h00, 0, 0, 16, 0, -1);
        repeat (4) @(posedge clk16);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_fetch.md
# video_fetch

Character-slot video fetcher and pixel serializer. It sits directly downstream of `crtc`. On each character-clock slot it takes the CRTC's display-enable, memory address and raster line, reads the character code from video RAM and then the glyph row from character ROM over the shared 17-bit bus, and shifts the 8 pixels out at 8 MHz during the following slot. Its `video` output feeds the monitor interface together with `crtc`'s `hsync`/`vsync`.

## Interface
Parameters:
- `VRAM_BASE`, 17'h08000, bus address of video RAM character 0.
- `CROM_BASE`, 17'h10000, bus address of character ROM byte 0.

Ports:
- `clk16`  in  1  16 MHz system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cclk_en`  in  1  one-cycle strobe marking the start of a character slot; nominally every 16 `clk16` cycles.
- `de`  in  1  display enable for the slot; sampled only when `cclk_en`=1.
- `ma`  in  10  character address; sampled only when `cclk_en`=1.
- `ra`  in  3  raster line within the character row; sampled only when `cclk_en`=1.
- `graphic`  in  1  charset select, used as ROM address bit 10; sampled only when `cclk_en`=1.
- `bus_req`  out  1  bus read request, held until acknowledged.
- `bus_addr`  out  17  read address; valid while `bus_req`=1.
- `bus_ack`  in  1  one-cycle acknowledge; `bus_data` is valid in the same cycle.
- `bus_data`  in  8  read data.
- `video`  out  1  serialized pixel, 1 = lit.
- `underrun`  out  1  one-cycle pulse when a fetch misses its slot deadline.

## Operation
- FSM states: IDLE, FETCH_CHAR, FETCH_PIX, READY.
- On `cclk_en` (any state):
  - Capture `de`, `ma`, `ra` and `graphic`.
  - Load the shift register `sr` from the pending slot: `pattern ^ {8{code[7]}}` if the state is READY; 8'h00 otherwise.
  - If the state is FETCH_CHAR or FETCH_PIX, pulse `underrun` and abandon the fetch.
  - Next state: FETCH_CHAR if `de`=1, else IDLE.
- FETCH_CHAR:
  - `bus_req`=1, `bus_addr` = `VRAM_BASE + {7'b0, ma}`.
  - On `bus_ack`, latch `code` = `bus_data` and go to FETCH_PIX.
- FETCH_PIX:
  - `bus_req`=1, `bus_addr` = `CROM_BASE + {6'b0, graphic, code[6:0], ra}`.
  - On `bus_ack`, latch `pattern` = `bus_data` and go to READY.
- READY: `bus_req`=0. Hold until `cclk_en`.
- Address arithmetic is 17-bit. Carry out of bit 16 is discarded.
- `bus_ack` is ignored in IDLE and READY, and in any cycle where `bus_req`=0.
- `cclk_en` takes priority over `bus_ack` in the same cycle. The ack is discarded and `underrun` pulses.
- `video` = `sr[7]`. MSB is the leftmost pixel.

## Timing
- Reset values:
  - state = IDLE, `bus_req`=0, `bus_addr`=0
  - `sr`=0, so `video`=0
  - `underrun`=0
  - `slot_cnt`=15
  - `code`=0, `pattern`=0
- `slot_cnt` (4-bit):
  - Set to 0 on the edge where `cclk_en`=1.
  - Otherwise increments, saturating at 15.
- `sr` shifts left, filling with 0, on edges where `slot_cnt` ∈ {1,3,5,7,9,11,13} and `cclk_en`=0.
- Each pixel is therefore held 2 cycles. Pixel k is visible while `slot_cnt` ∈ {2k, 2k+1}.
- Latency: pixels fetched in slot N appear in slot N+1. The first pixel appears 1 cycle after the `cclk_en` that starts slot N+1.
- `bus_req` rises the cycle after `cclk_en`.
- Fetch timing:
  - The ROM request immediately follows the VRAM ack, with no idle cycle.
  - Best case is READY 3 cycles after `cclk_en`, with each ack arriving the cycle after its request.
  - Both acks must arrive within 15 cycles of `cclk_en` to avoid underrun.
- Short slot (`cclk_en` fewer than 16 cycles apart): the slot is truncated and the new load wins.
- Long slot: `slot_cnt` saturates and pixel 7 is held until the next `cclk_en`.
- Reset mid-fetch: `bus_req`=0 on the next cycle. No `underrun` pulse.

## Test plan
- Reset, then 3 slots with `de`=0 → `bus_req` never asserts; `video`=0 throughout; `underrun`=0.
- `cclk_en` every 16 cycles, `de`=1, `ma`=10'h005, `ra`=3, `graphic`=0. Ack VRAM with 8'h41 and ROM with 8'hA5, each 1 cycle after request.
  - `bus_addr` = 17'h08005, then 17'h1020B.
  - Next slot `video` = 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1.
- Same as above but code 8'hC1 → ROM address 17'h1020B; displayed pattern is 8'h5A (inverted).
- `graphic`=1, code 8'h00, `ra`=7 → ROM address 17'h10407.
- Hold ROM ack off until after the next `cclk_en`:
  - `underrun` pulses once.
  - Following slot is blank.
  - `bus_req` re-asserts for the new slot with the new `ma`.
  - The late ack is ignored.
- Assert `reset` while in FETCH_PIX → next cycle `bus_req`=0, `video`=0, `underrun`=0. Next `cclk_en` with `de`=1 fetches normally.
